// File: rtl/uart_frame_engine.sv
// uart_frame_engine: checksummed request/response frame processor; PARSER_TIMEOUT_EN adds an inter-byte parser timeout.
module uart_frame_engine #(
  parameter int         MAX_PAYLOAD    = 64,
  parameter logic [7:0] ADD_CONST      = 8'h01,
  parameter logic [7:0] REQ_SOF        = 8'hA5,
  parameter logic [7:0] RSP_SOF        = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_val,
  output logic       in_rdy,
  output logic [7:0] out_data,
  output logic       out_val,
  input  logic       out_rdy,
  output logic       busy,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);
  localparam logic [3:0] R_IDLE = 4'd0, R_LEN = 4'd1, R_CMD = 4'd2, R_PAY = 4'd3, R_CHK = 4'd4, R_DRAIN = 4'd5;
  localparam logic [3:0] T_SOF = 4'd8, T_LEN = 4'd9, T_STAT = 4'd10, T_PAY = 4'd11, T_CHK = 4'd12;
  localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);
  logic [3:0] state;
  logic [7:0] len, cmd, chk, idx, stat, rchk, raw, pay_xf, stat_sel;
  logic [8:0] cnt;
  logic [7:0] mem [0:(1<<AW)-1];
  logic in_fire, out_fire;
`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif
  // Transmit states all carry bit 3, so the receive side is simply !state[3].
  assign in_rdy = rst_n && !state[3];
  assign busy = state != R_IDLE;
  assign in_fire = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;
  always_comb begin
    raw = mem[idx[AW-1:0]];
    pay_xf = cmd == 8'h02 ? raw + ADD_CONST : cmd == 8'h03 ? ~raw : raw;
    stat_sel = in_data != chk ? 8'hE2 : (cmd == 8'h00 || cmd > 8'h03) ? 8'hE1 : cmd;
  end
  always_ff @(posedge clk)
    if (state == R_PAY && in_fire) mem[idx[AW-1:0]] <= in_data;
  // rchk always holds the XOR of every byte already loaded into out_data after SOF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= R_IDLE;
      len <= '0;
      cmd <= '0;
      chk <= '0;
      idx <= '0;
      stat <= '0;
      rchk <= '0;
      cnt <= '0;
      out_data <= '0;
      out_val <= 1'b0;
      frames_ok <= '0;
      frames_err <= '0;
    end else begin
      case (state)
        R_IDLE: if (in_fire && in_data == REQ_SOF) state <= R_LEN;
        R_LEN: if (in_fire) begin
          len <= in_data;
          chk <= in_data;
          idx <= '0;
          cnt <= {1'b0, in_data} + 9'd2;
          state <= in_data > MAXP ? R_DRAIN : R_CMD;
        end
        R_CMD: if (in_fire) begin
          cmd <= in_data;
          chk <= chk ^ in_data;
          state <= len != 8'd0 ? R_PAY : R_CHK;
        end
        R_PAY: if (in_fire) begin
          chk <= chk ^ in_data;
          idx <= idx + 8'd1;
          if (idx == len - 8'd1) state <= R_CHK;
        end
        R_CHK: if (in_fire) begin
          stat <= stat_sel;
          if (stat_sel >= 8'hE0) len <= '0;
          idx <= '0;
          out_data <= RSP_SOF;
          out_val <= 1'b1;
          state <= T_SOF;
        end
        R_DRAIN: if (in_fire) begin
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            stat <= 8'hE3;
            len <= '0;
            idx <= '0;
            out_data <= RSP_SOF;
            out_val <= 1'b1;
            state <= T_SOF;
          end
        end
        T_SOF: if (out_fire) begin
          out_data <= len;
          rchk <= len;
          state <= T_LEN;
        end
        T_LEN: if (out_fire) begin
          out_data <= stat;
          rchk <= rchk ^ stat;
          state <= T_STAT;
        end
        T_STAT, T_PAY: if (out_fire) begin
          if (idx == len) begin
            out_data <= rchk;
            state <= T_CHK;
          end else begin
            out_data <= pay_xf;
            rchk <= rchk ^ pay_xf;
            idx <= idx + 8'd1;
            state <= T_PAY;
          end
        end
        T_CHK: if (out_fire) begin
          out_val <= 1'b0;
          state <= R_IDLE;
          if (stat < 8'hE0) frames_ok <= frames_ok + {15'd0, frames_ok != 16'hFFFF};
          else frames_err <= frames_err + {15'd0, frames_err != 16'hFFFF};
        end
        default: state <= R_IDLE;
      endcase
`ifdef PARSER_TIMEOUT_EN
      if (state != R_IDLE && !state[3]) begin
        if (in_fire) tcnt <= '0;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tcnt <= '0;
          state <= R_IDLE;
          frames_err <= frames_err + {15'd0, frames_err != 16'hFFFF};
        end else tcnt <= tcnt + 1'b1;
      end else tcnt <= '0;
`endif
    end
`ifdef PARSER_TIMEOUT_EN
    if (!rst_n) tcnt <= '0;
`endif
  end
endmodule

// File: tb/tb_uart_frame_engine.sv
// tb_uart_frame_engine: directed frame vectors with hand-computed responses; MAX_PAYLOAD = 4.
module tb_uart_frame_engine;
  logic clk = 1'b0, rst_n = 1'b0, in_val = 1'b0, out_rdy = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_rdy, out_val, busy;
  logic [7:0] out_data;
  logic [15:0] frames_ok, frames_err;
  int tests = 0, fails = 0, bad_rdy = 0;
  logic [7:0] rx[$], eq[$], sq[$];
  logic sdone;
  always #5 clk = ~clk;
  uart_frame_engine #(.MAX_PAYLOAD(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .busy(busy),
    .frames_ok(frames_ok), .frames_err(frames_err)
  );
  // Inputs only change 1 time unit after posedge, so negedge values match the next edge.
  always @(negedge clk) begin
    if (rst_n && out_val && out_rdy) rx.push_back(out_data);
    if (out_val && in_rdy) bad_rdy++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_val = 1'b1;
    while (!in_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("send_timeout", 32'(n), 0);
    @(posedge clk);
    #1 in_val = 1'b0;
  endtask
  task automatic send_q();
    foreach (sq[i]) send(sq[i]);
  endtask
  task automatic expect_rsp(input string tag);
    int n = 0;
    while (rx.size() < eq.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 32'(rx.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < rx.size(); i++) check($sformatf("%s_b%0d", tag, i), {24'd0, rx[i]}, {24'd0, eq[i]});
    rx.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", {31'd0, in_rdy}, 0);
    check("rst_out_val", {31'd0, out_val}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ok", {16'd0, frames_ok}, 0);
    check("rst_err", {16'd0, frames_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_rdy", {31'd0, in_rdy}, 1);
    sq = '{8'hA5, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30};
    send_q();
    eq = '{8'h5A, 8'h02, 8'h02, 8'h11, 8'h21, 8'h30};
    expect_rsp("add");
    check("add_ok", {16'd0, frames_ok}, 1);
    sq = '{8'hA5, 8'h01, 8'h01, 8'h33, 8'h33, 8'hA5, 8'h01, 8'h03, 8'h0F, 8'h0D};
    send_q();
    eq = '{8'h5A, 8'h01, 8'h01, 8'h33, 8'h33, 8'h5A, 8'h01, 8'h03, 8'hF0, 8'hF2};
    expect_rsp("echo_inv");
    check("echo_inv_ok", {16'd0, frames_ok}, 3);
    sq = '{8'hA5, 8'h01, 8'h01, 8'h33, 8'h00, 8'hA5, 8'h00, 8'h07, 8'h07};
    send_q();
    eq = '{8'h5A, 8'h00, 8'hE2, 8'hE2, 8'h5A, 8'h00, 8'hE1, 8'hE1};
    expect_rsp("errs");
    check("errs_err", {16'd0, frames_err}, 2);
    check("errs_ok", {16'd0, frames_ok}, 3);
    sq = '{8'h00, 8'hFF, 8'hA5, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
           8'hA5, 8'h00, 8'h01, 8'h01};
    send_q();
    eq = '{8'h5A, 8'h00, 8'hE3, 8'hE3, 8'h5A, 8'h00, 8'h01, 8'h01};
    expect_rsp("oversize");
    check("oversize_err", {16'd0, frames_err}, 3);
    check("oversize_ok", {16'd0, frames_ok}, 4);
    sq = '{8'hA5, 8'h04, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
    send_q();
    eq = '{8'h5A, 8'h04, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
    expect_rsp("max_len");
    check("max_len_ok", {16'd0, frames_ok}, 5);
    bad_rdy = 0;
    sdone = 1'b0;
    sq = '{8'hA5, 8'h03, 8'h02, 8'hFE, 8'hFF, 8'h00, 8'h00};
    fork
      begin send_q(); sdone = 1'b1; end
      begin
        int n = 0;
        while ((!sdone || rx.size() < 7) && n < 3000) begin
          @(posedge clk);
          #1 out_rdy = 1'($urandom_range(0, 1));
          n++;
        end
        out_rdy = 1'b1;
      end
    join
    eq = '{8'h5A, 8'h03, 8'h02, 8'hFF, 8'h00, 8'h01, 8'hFF};
    expect_rsp("backpressure");
    check("bp_in_rdy_low", 32'(bad_rdy), 0);
    check("bp_ok", {16'd0, frames_ok}, 6);
    out_rdy = 1'b0;
    sq = '{8'hA5, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'h12};
    send_q();
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (!out_val && n < 100) begin
        @(negedge clk);
        n++;
      end
      out_rdy = 1'b1;
      @(posedge clk);
      #1 out_rdy = 1'b0;
    end
    check("tpay_data", {24'd0, out_data}, 32'h0000_00AA);
    check("tpay_val", {31'd0, out_val}, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_val", {31'd0, out_val}, 0);
    check("mid_rst_ok", {16'd0, frames_ok}, 0);
    check("mid_rst_err", {16'd0, frames_err}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx.delete();
    sq = '{8'hA5, 8'h00, 8'h01, 8'h01};
    send_q();
    eq = '{8'h5A, 8'h00, 8'h01, 8'h01};
    expect_rsp("recover");
    check("recover_ok", {16'd0, frames_ok}, 1);
`ifdef PARSER_TIMEOUT_EN
    sq = '{8'hA5, 8'h02};
    send_q();
    repeat (51) @(posedge clk);
    #1;
    check("timeout_busy", {31'd0, busy}, 0);
    check("timeout_err", {16'd0, frames_err}, 1);
    check("timeout_no_out", 32'(rx.size()), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
